perf_stats_response_tracker: RTL

Response-side counterpart to the request logger in the memory-controller performance-statistics path. Captures every accepted request (ID, address, direction, issue cycle) into an in-order outstanding queue, and retires the oldest entry on every response. For each retirement it emits a per-request latency record and updates running aggregates: count, sum, min and max latency. Flags protocol violations such as overflow, underflow and address mismatch. Sits beside the controller's request/response handshake, fully synthesizable; simulation dumping of records is done downstream.

---
 rtl/perf_stats_pkg.sv | 26 ++
 rtl/perf_stats_response_tracker_if.sv | 29 ++
 rtl/perf_stats_fifo.sv | 48 ++++
 rtl/perf_stats_response_tracker.sv | 105 ++++++++++
 4 files changed

// File: rtl/perf_stats_pkg.sv
// Shared types and helpers for the performance-statistics response tracker.
// Queue entries and the latency helper are sized by the package default widths.
package perf_stats_pkg;

  localparam int DEF_DEPTH   = 16;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_CYCLE_W = 64;
  localparam int DEF_LAT_W   = 32;
  localparam int ID_W        = 32;

  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic [DEF_ADDR_W-1:0]  addr;
    logic                   is_write;
    logic [DEF_CYCLE_W-1:0] cycle;
  } entry_t;

  // Clamp a raw cycle delta to the largest representable latency.
  function automatic logic [DEF_LAT_W-1:0] sat_lat(input logic [DEF_CYCLE_W-1:0] delta);
    if (delta > DEF_CYCLE_W'({DEF_LAT_W{1'b1}}))
      return {DEF_LAT_W{1'b1}};
    else
      return delta[DEF_LAT_W-1:0];
  endfunction

endpackage

// File: rtl/perf_stats_response_tracker_if.sv
// Request/response handshake plus the per-request latency record.
interface perf_stats_response_tracker_if #(
  parameter int ADDR_W  = 32,
  parameter int CYCLE_W = 64,
  parameter int LAT_W   = 32
);
  logic               req_fire;
  logic               req_rd;
  logic               req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic               resp_fire;
  logic [ADDR_W-1:0]  resp_addr;
  logic [CYCLE_W-1:0] global_cycle;

  logic               lat_valid;
  logic [31:0]        lat_id;
  logic [LAT_W-1:0]   lat_cycles;
  logic               lat_is_write;

  modport master (
    output req_fire, req_rd, req_wr, req_addr, resp_fire, resp_addr, global_cycle,
    input  lat_valid, lat_id, lat_cycles, lat_is_write
  );

  modport slave (
    input  req_fire, req_rd, req_wr, req_addr, resp_fire, resp_addr, global_cycle,
    output lat_valid, lat_id, lat_cycles, lat_is_write
  );
endinterface

// File: rtl/perf_stats_fifo.sv
// In-order queue of outstanding request entries; push and pop may share a cycle.
module perf_stats_fifo
  import perf_stats_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/perf_stats_response_tracker.sv
// Retires outstanding requests on responses, emitting latency records and
// running aggregates with sticky protocol-error flags.
module perf_stats_response_tracker
  import perf_stats_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CYCLE_W = DEF_CYCLE_W,
  parameter int LAT_W   = DEF_LAT_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  perf_stats_response_tracker_if.slave bus,
  output logic [$clog2(DEPTH):0]       outstanding,
  output logic [31:0]                  stat_rd_count,
  output logic [31:0]                  stat_wr_count,
  output logic [63:0]                  stat_lat_sum,
  output logic [LAT_W-1:0]             stat_lat_min,
  output logic [LAT_W-1:0]             stat_lat_max,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_addr_mismatch
);
  logic [ID_W-1:0]  id_cnt;
  entry_t           push_ent;
  entry_t           head;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic [LAT_W-1:0] lat_now;
  logic [64:0]      sum_wide;

  logic             lat_valid_q;
  logic [31:0]      lat_id_q;
  logic [LAT_W-1:0] lat_cycles_q;
  logic             lat_is_write_q;

  // A full queue still accepts a request when a response frees the head slot.
  assign do_pop  = bus.resp_fire && !empty;
  assign do_push = bus.req_fire && (!full || do_pop);

  always_comb begin
    push_ent          = '0;
    push_ent.id       = id_cnt;
    push_ent.addr     = DEF_ADDR_W'(bus.req_addr);
    push_ent.is_write = bus.req_wr && !bus.req_rd;
    push_ent.cycle    = DEF_CYCLE_W'(bus.global_cycle);
  end

  assign lat_now  = LAT_W'(sat_lat(DEF_CYCLE_W'(bus.global_cycle - CYCLE_W'(head.cycle))));
  assign sum_wide = {1'b0, stat_lat_sum} + 65'(lat_now);

  perf_stats_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (do_push),
    .din     (push_ent),
    .pop     (do_pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (outstanding)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_cnt            <= '0;
      lat_valid_q       <= 1'b0;
      lat_id_q          <= '0;
      lat_cycles_q      <= '0;
      lat_is_write_q    <= 1'b0;
      stat_rd_count     <= '0;
      stat_wr_count     <= '0;
      stat_lat_sum      <= '0;
      stat_lat_min      <= '1;
      stat_lat_max      <= '0;
      err_overflow      <= 1'b0;
      err_underflow     <= 1'b0;
      err_addr_mismatch <= 1'b0;
    end else begin
      lat_valid_q <= do_pop;
      if (bus.req_fire) id_cnt <= id_cnt + 32'd1;
      if (bus.req_fire && !do_push) err_overflow <= 1'b1;
      if (bus.resp_fire && empty)   err_underflow <= 1'b1;
      if (do_pop) begin
        lat_id_q       <= head.id;
        lat_cycles_q   <= lat_now;
        lat_is_write_q <= head.is_write;
        if (head.is_write) stat_wr_count <= stat_wr_count + 32'd1;
        else               stat_rd_count <= stat_rd_count + 32'd1;
        stat_lat_sum <= sum_wide[64] ? '1 : sum_wide[63:0];
        if (lat_now < stat_lat_min) stat_lat_min <= lat_now;
        if (lat_now > stat_lat_max) stat_lat_max <= lat_now;
        if (bus.resp_addr != ADDR_W'(head.addr)) err_addr_mismatch <= 1'b1;
      end
    end
  end

  assign bus.lat_valid    = lat_valid_q;
  assign bus.lat_id       = lat_id_q;
  assign bus.lat_cycles   = lat_cycles_q;
  assign bus.lat_is_write = lat_is_write_q;

endmodule
